// File: rtl/fcvt_arbiter_if.sv
// Request/response and converter-side signal bundle for fcvt_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the converter.
interface fcvt_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_x;
    logic           cvt_valid;
    logic           cvt_op;
    logic [W-1:0]   cvt_x;
    logic [W-1:0]   cvt_y;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_y;
    logic           busy;

    modport slave (
        input  req_valid, req_op, req_x, cvt_y,
        output req_ready, cvt_valid, cvt_op, cvt_x, resp_valid, resp_y, busy
    );

    modport master (
        output req_valid, req_op, req_x, cvt_y,
        input  req_ready, cvt_valid, cvt_op, cvt_x, resp_valid, resp_y, busy
    );
endinterface

// File: rtl/fcvt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float/int converter between N requesters,
// with a tag pipeline that routes each result back to its owner as a one-cycle pulse.
module fcvt_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 0,
    parameter int W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    fcvt_arbiter_if.slave bus
);
    localparam int             PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]    N_WIDE = (PW + 1)'(N);
    localparam logic [N-1:0]   OH_ONE = N'(1);

    logic [W-1:0]  x_arr [N];
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] grant_idx;
    logic          grant_any;
    logic [N-1:0]  grant_oh;
    logic [PW:0]   cand;

    logic          cvt_op_reg;
    logic [W-1:0]  cvt_x_reg;
    logic [LAT:0]  tag_v_reg;
    logic [N-1:0]  tag_own_reg [LAT+1];
    logic [N-1:0]  resp_valid_reg;
    logic [W-1:0]  resp_y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign x_arr[gi] = bus.req_x[W*gi +: W];
        end
    endgenerate

    // Scan from the farthest candidate back to ptr so the last hit is the nearest one.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (PW + 1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (bus.req_valid[cand[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (rst) begin
            grant_any = 1'b0;
        end
    end

    assign grant_oh = grant_any ? (OH_ONE << grant_idx) : '0;
    assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg        <= '0;
            cvt_op_reg     <= 1'b0;
            cvt_x_reg      <= '0;
            tag_v_reg      <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_own_reg[s] <= '0;
            end
            resp_valid_reg <= '0;
            resp_y_reg     <= '0;
        end else begin
            if (grant_any) begin
                ptr_reg    <= ptr_next;
                cvt_op_reg <= bus.req_op[grant_idx];
                cvt_x_reg  <= x_arr[grant_idx];
            end
            tag_v_reg[0]   <= grant_any;
            tag_own_reg[0] <= grant_oh;
            for (int s = 1; s <= LAT; s++) begin
                tag_v_reg[s]   <= tag_v_reg[s-1];
                tag_own_reg[s] <= tag_own_reg[s-1];
            end
            // The last stage lines up with cvt_y for the operation issued LAT cycles earlier.
            resp_valid_reg <= tag_v_reg[LAT] ? tag_own_reg[LAT] : '0;
            if (tag_v_reg[LAT]) begin
                resp_y_reg <= bus.cvt_y;
            end
        end
    end

    // Stage 0 of the tag pipeline is exactly the issue strobe.
    assign bus.cvt_valid  = tag_v_reg[0];
    assign bus.cvt_op     = cvt_op_reg;
    assign bus.cvt_x      = cvt_x_reg;
    assign bus.req_ready  = grant_oh;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_y     = resp_y_reg;
    assign bus.busy       = (|tag_v_reg) | (|resp_valid_reg);
endmodule

// File: tb/tb_fcvt_arbiter.sv
// Bench for fcvt_arbiter: LAT=0 and LAT=3 instances driven by the same requests, each with a
// converter model, checked against a queue-based reference of grants and expected responses.
module tb_fcvt_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int          due;
        logic [3:0]  own;
        logic [31:0] y;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   rv;
    logic [N-1:0]   rop;
    logic [N*W-1:0] rx;

    fcvt_arbiter_if #(.N(N), .W(W)) bus0 ();
    fcvt_arbiter_if #(.N(N), .W(W)) bus1 ();

    fcvt_arbiter #(.N(N), .LAT(0), .W(W)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fcvt_arbiter #(.N(N), .LAT(3), .W(W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [31:0] ftoi(input logic [31:0] f);
        int          e;
        logic [31:0] mag;
        logic [31:0] m;
        e = int'(f[30:23]) - 127;
        m = {8'd0, 1'b1, f[22:0]};
        if (e < 0) return 32'd0;
        if (e > 30) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (e >= 23) mag = m << (e - 23);
        else         mag = m >> (23 - e);
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] itof(input logic [31:0] i);
        logic [31:0] mag;
        logic [31:0] frac;
        int          p;
        if (i == 32'd0) return 32'd0;
        mag = i[31] ? -i : i;
        p = 0;
        for (int b = 0; b < 32; b++) if (mag[b]) p = b;
        if (p >= 23) frac = mag >> (p - 23);
        else         frac = mag << (23 - p);
        return {i[31], 8'(p + 127), frac[22:0]};
    endfunction

    function automatic logic [31:0] conv(input logic op, input logic [31:0] x);
        return op ? itof(x) : ftoi(x);
    endfunction

    function automatic logic [127:0] lane(input int i, input logic [31:0] v);
        return 128'(v) << (32 * i);
    endfunction

    // Converter models: combinational for dut0, three register stages for dut1.
    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= conv(bus1.cvt_op, bus1.cvt_x);
        p2 <= p1;
        p3 <= p2;
    end

    assign bus0.req_valid = rv;
    assign bus0.req_op    = rop;
    assign bus0.req_x     = rx;
    assign bus0.cvt_y     = conv(bus0.cvt_op, bus0.cvt_x);
    assign bus1.req_valid = rv;
    assign bus1.req_op    = rop;
    assign bus1.req_x     = rx;
    assign bus1.cvt_y     = p3;

    logic [3:0]  o_ready [2];
    logic [3:0]  o_rv    [2];
    logic [31:0] o_ry    [2];
    logic [31:0] o_cx    [2];
    logic        o_cv    [2];
    logic        o_busy  [2];
    assign o_ready[0] = bus0.req_ready;  assign o_ready[1] = bus1.req_ready;
    assign o_rv[0]    = bus0.resp_valid; assign o_rv[1]    = bus1.resp_valid;
    assign o_ry[0]    = bus0.resp_y;     assign o_ry[1]    = bus1.resp_y;
    assign o_cx[0]    = bus0.cvt_x;      assign o_cx[1]    = bus1.cvt_x;
    assign o_cv[0]    = bus0.cvt_valid;  assign o_cv[1]    = bus1.cvt_valid;
    assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_err;
    int          ptr_m;
    int          ecount;
    int          lats [2];
    exp_t        exp_q [2][$];
    logic [31:0] last_y [2];
    logic        acc_last;
    logic [31:0] acc_x;
    logic [3:0]  last_ready0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check everything mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] o,
                         input logic [127:0] x);
        int         g;
        logic [3:0] exp_ready;
        logic [3:0] exp_rv;
        logic       busy_exp;
        exp_t       e;
        rst = r; rv = v; rop = o; rx = x;
        @(negedge clk);
        g = r ? -1 : model_grant(v, ptr_m);
        exp_ready = (g < 0) ? 4'd0 : (4'd1 << g);
        last_ready0 = o_ready[0];
        for (int d = 0; d < 2; d++) begin
            busy_exp = exp_q[d].size() != 0;
            exp_rv = 4'd0;
            if (exp_q[d].size() != 0 && exp_q[d][0].due == ecount) begin
                e = exp_q[d].pop_front();
                exp_rv = e.own;
                last_y[d] = e.y;
                $display("txn dut%0d owner=%b y=%h", d, e.own, e.y);
            end
            chk($sformatf("dut%0d.req_ready", d), 32'(o_ready[d]), 32'(exp_ready));
            chk($sformatf("dut%0d.cvt_valid", d), 32'(o_cv[d]), 32'(acc_last));
            if (acc_last) chk($sformatf("dut%0d.cvt_x", d), o_cx[d], acc_x);
            chk($sformatf("dut%0d.resp_valid", d), 32'(o_rv[d]), 32'(exp_rv));
            chk($sformatf("dut%0d.resp_y", d), o_ry[d], last_y[d]);
            chk($sformatf("dut%0d.busy", d), 32'(o_busy[d]), 32'(busy_exp));
        end
        @(posedge clk);
        ecount++;
        if (r) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                last_y[d] = 32'd0;
            end
            ptr_m = 0;
            acc_last = 1'b0;
        end else if (g >= 0) begin
            acc_last = 1'b1;
            acc_x = x[32*g +: 32];
            for (int d = 0; d < 2; d++) begin
                e.due = ecount + 1 + lats[d];
                e.own = 4'd1 << g;
                e.y   = conv(o[g], x[32*g +: 32]);
                exp_q[d].push_back(e);
            end
            ptr_m = (g + 1) % N;
        end else begin
            acc_last = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 128'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; ptr_m = 0; ecount = 0;
        lats[0] = 0; lats[1] = 3;
        last_y[0] = 32'd0; last_y[1] = 32'd0;
        acc_last = 1'b0; acc_x = 32'd0; last_ready0 = 4'd0;
        rst = 1'b1; rv = 4'd0; rop = 4'd0; rx = 128'd0;
        @(posedge clk); #1;
        cycle(1'b1, 4'd0, 4'd0, 128'd0);
        cycle(1'b1, 4'd0, 4'd0, 128'd0);

        chk("reset.cvt_valid", 32'(bus0.cvt_valid), 32'd0);
        chk("reset.cvt_op", 32'(bus0.cvt_op), 32'd0);
        chk("reset.cvt_x", bus0.cvt_x, 32'd0);
        chk("reset.resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("reset.resp_y", bus1.resp_y, 32'd0);
        chk("reset.busy", 32'(bus1.busy), 32'd0);
        idle(2);

        // Single ftoi request from requester 2.
        cycle(1'b0, 4'b0100, 4'd0, lane(2, 32'h4040_0000));
        chk("single.ready", 32'(last_ready0), 32'h4);
        chk("single.cvt_x", bus0.cvt_x, 32'h4040_0000);
        idle(1);
        chk("single.resp_valid", 32'(bus0.resp_valid), 32'h4);
        chk("single.resp_y", bus0.resp_y, 32'h0000_0003);
        idle(1);
        chk("single.busy_after", 32'(bus0.busy), 32'd0);
        idle(4);

        // Negative value and sub-unity value.
        cycle(1'b0, 4'b0001, 4'd0, lane(0, 32'hC040_0000));
        idle(1);
        chk("neg.resp_valid", 32'(bus0.resp_valid), 32'h1);
        chk("neg.resp_y", bus0.resp_y, 32'hFFFF_FFFD);
        cycle(1'b0, 4'b0001, 4'd0, lane(0, 32'h3F00_0000));
        idle(1);
        chk("half.resp_y", bus0.resp_y, 32'h0000_0000);
        idle(5);

        // Round-robin with all requesters valid, starting from a freshly reset pointer.
        cycle(1'b1, 4'd0, 4'd0, 128'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b1111, 4'b1010,
                  {32'(i * 16 + 4), 32'(i * 16 + 3), 32'h4100_0000 + 32'(i), 32'h4000_0000 + 32'(i)});
            chk("rr.grant", 32'(last_ready0), 32'd1 << (i % 4));
        end
        idle(6);

        // Pointer skip/wrap: pointer lands on 3, then only requester 1, then 1 and 3.
        cycle(1'b0, 4'b0100, 4'd0, lane(2, 32'h4120_0000));
        cycle(1'b0, 4'b0010, 4'd0, lane(1, 32'h4140_0000));
        chk("wrap.grant1", 32'(last_ready0), 32'h2);
        cycle(1'b0, 4'b1010, 4'd0, lane(1, 32'h4160_0000) | lane(3, 32'h4180_0000));
        chk("wrap.grant3", 32'(last_ready0), 32'h8);
        idle(6);

        // Reset while LAT=3 operations are in flight: they must vanish.
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 4'd0, {4{32'h4200_0000 + 32'(i)}});
        cycle(1'b1, 4'd0, 4'd0, 128'd0);
        chk("midrst.busy", 32'(bus1.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("midrst.no_resp", 32'(bus1.resp_valid), 32'd0);
        end
        cycle(1'b0, 4'b0010, 4'd0, lane(1, 32'h4120_0000));
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("fresh.early", 32'(bus1.resp_valid), 32'd0);
        end
        idle(1);
        chk("fresh.resp_valid", 32'(bus1.resp_valid), 32'h2);
        chk("fresh.resp_y", bus1.resp_y, 32'h0000_000A);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 49) == 0, 4'($urandom), 4'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
